// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client arbiter (instruction fetch, load/store) onto one
// single-port memory. Each access runs IDLE -> ACC -> DONE with a wait-cycle
// timeout. All outputs are registered.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise load/store has fixed priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_valid,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, IF_ACC, LS_ACC, DONE} state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        pick_ls;
    logic [8:0]  wait_next;
    logic        acc_done;
    logic        acc_err;
    logic [31:0] acc_rdata;

`ifdef MEM_ARBITER_RR_EN
    logic        last_ls;
`endif

    // Winner selection among the requests seen in IDLE
    always_comb begin
        pick_ls = ls_req;
`ifdef MEM_ARBITER_RR_EN
        if (if_req && ls_req)
            pick_ls = !last_ls;
`endif
    end

    // Completion / timeout decision for the current access cycle
    always_comb begin
        wait_next = {1'b0, wait_cnt} + 9'd1;
        acc_done  = 1'b0;
        acc_err   = 1'b0;
        acc_rdata = '0;
        if (mem_ready) begin
            acc_done  = 1'b1;
            acc_rdata = mem_we ? '0 : mem_rdata;
        end else if (wait_next == TIMEOUT_W) begin
            acc_done = 1'b1;
            acc_err  = 1'b1;
        end
    end

    // Arbitration FSM with registered grant, completion and memory outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_gnt    <= 1'b0;
            ls_valid  <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_ls   <= 1'b1;
`endif
        end else begin
            if_gnt   <= 1'b0;
            ls_gnt   <= 1'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            if_err   <= 1'b0;
            ls_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
`ifdef MEM_ARBITER_RR_EN
                        last_ls  <= pick_ls;
`endif
                        if (pick_ls) begin
                            state     <= LS_ACC;
                            ls_gnt    <= 1'b1;
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                        end else begin
                            state     <= IF_ACC;
                            if_gnt    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                IF_ACC, LS_ACC: begin
                    if (!mem_ready)
                        wait_cnt <= wait_next[7:0];
                    if (acc_done) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (state == LS_ACC) begin
                            ls_valid <= 1'b1;
                            ls_err   <= acc_err;
                            ls_rdata <= acc_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_err   <= acc_err;
                            if_rdata <= acc_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
